// File: rtl/feature_pingpong_ctrl.sv
// Ping-pong scheduler for the two feature memory banks: grants the fetcher and the
// line buffer exclusive use of one bank each and tracks per-bank fill state and line count.
module feature_pingpong_ctrl #(
   parameter int LINE_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      fetch_req,
   output logic                      fetch_grant,
   output logic                      wr_bank_sel,
   input  logic                      fetch_done,
   input  logic [LINE_CNT_WIDTH-1:0] fill_lines,
   input  logic                      consume_req,
   output logic                      consume_grant,
   output logic                      rd_bank_sel,
   output logic [LINE_CNT_WIDTH-1:0] rd_lines,
   input  logic                      consume_done,
   output logic [1:0]                bank_empty,
   output logic [1:0]                bank_full,
   output logic                      busy,
   output logic                      protocol_err
);

   localparam logic [1:0] ST_EMPTY    = 2'd0;
   localparam logic [1:0] ST_FILLING  = 2'd1;
   localparam logic [1:0] ST_FULL     = 2'd2;
   localparam logic [1:0] ST_DRAINING = 2'd3;

   logic [1:0][1:0]                state_q, state_d;
   logic [1:0][LINE_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                           wr_ptr_q, wr_ptr_d;
   logic                           rd_ptr_q, rd_ptr_d;
   logic                           fetch_grant_q, fetch_grant_d;
   logic                           consume_grant_q, consume_grant_d;
   logic [LINE_CNT_WIDTH-1:0]      rd_lines_q, rd_lines_d;
   logic                           err_q, err_d;

   // Only the bank under wr_ptr can be FILLING and only the one under rd_ptr DRAINING,
   // so the outstanding-transfer flags fall straight out of the bank state.
   logic wr_open, rd_open, fetch_ok, consume_ok;
   assign wr_open    = (state_q[wr_ptr_q] == ST_FILLING);
   assign rd_open    = (state_q[rd_ptr_q] == ST_DRAINING);
   assign fetch_ok   = fetch_req   && (state_q[wr_ptr_q] == ST_EMPTY);
   assign consume_ok = consume_req && (state_q[rd_ptr_q] == ST_FULL);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      rd_lines_d      = rd_lines_q;
      fetch_grant_d   = 1'b0;
      consume_grant_d = 1'b0;
      err_d           = 1'b0;
      if (flush) begin
         state_d  = {ST_EMPTY, ST_EMPTY};
         cnt_d    = '0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         err_d = (fetch_done && !wr_open) || (consume_done && !rd_open);
         if (fetch_ok) begin
            state_d[wr_ptr_q] = ST_FILLING;
            fetch_grant_d     = 1'b1;
         end
         if (fetch_done && wr_open) begin
            if (fill_lines != '0) begin
               state_d[wr_ptr_q] = ST_FULL;
               cnt_d[wr_ptr_q]   = fill_lines;
               wr_ptr_d          = ~wr_ptr_q;
            end else begin
               state_d[wr_ptr_q] = ST_EMPTY;
            end
         end
         if (consume_ok) begin
            state_d[rd_ptr_q] = ST_DRAINING;
            consume_grant_d   = 1'b1;
            rd_lines_d        = cnt_q[rd_ptr_q];
         end
         if (consume_done && rd_open) begin
            state_d[rd_ptr_q] = ST_EMPTY;
            rd_ptr_d          = ~rd_ptr_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= {ST_EMPTY, ST_EMPTY};
         cnt_q           <= '0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         fetch_grant_q   <= 1'b0;
         consume_grant_q <= 1'b0;
         rd_lines_q      <= '0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         fetch_grant_q   <= fetch_grant_d;
         consume_grant_q <= consume_grant_d;
         rd_lines_q      <= rd_lines_d;
         err_q           <= err_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_status
         assign bank_empty[gi] = (state_q[gi] == ST_EMPTY);
         assign bank_full[gi]  = (state_q[gi] == ST_FULL);
      end
   endgenerate

   assign busy          = ~&bank_empty;
   assign fetch_grant   = fetch_grant_q;
   assign consume_grant = consume_grant_q;
   assign wr_bank_sel   = wr_ptr_q;
   assign rd_bank_sel   = rd_ptr_q;
   assign rd_lines      = rd_lines_q;
   assign protocol_err  = err_q;

endmodule

// File: doc/feature_pingpong_ctrl.md
Name: feature_pingpong_ctrl

Overview:
- Ping-pong scheduler for the two scratchpad feature memory groups (bank 0 and bank 1).
- Sits between the input feature fetcher (producer, fills a bank from the data bus) and the line-buffer array (consumer, drains a bank).
- Grants each side exclusive access to one bank at a time, steers the fetcher write-select and consumer read-select, and tracks per-bank fill state and valid line count so that fetch of tile N+1 overlaps compute on tile N.

Parameters:
LINE_CNT_WIDTH, 8, width of per-bank valid-line count (fill_lines / rd_lines).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous clear of all bank state, priority over everything except rst
fetch_req  input  1  fetcher requests a bank to fill (level)
fetch_grant  output  1  one-cycle pulse: bank wr_bank_sel granted to fetcher
wr_bank_sel  output  1  bank the fetcher writes (drives feature write-select)
fetch_done  input  1  one-cycle pulse: granted bank fill complete
fill_lines  input  LINE_CNT_WIDTH  lines written, sampled with fetch_done
consume_req  input  1  line buffer requests a full bank (level)
consume_grant  output  1  one-cycle pulse: bank rd_bank_sel granted to consumer
rd_bank_sel  output  1  bank the consumer reads (drives feature_in_select)
rd_lines  output  LINE_CNT_WIDTH  valid line count of granted read bank, held until next grant
consume_done  input  1  one-cycle pulse: granted bank fully consumed
bank_empty  output  2  per-bank EMPTY status
bank_full  output  2  per-bank FULL status
busy  output  1  any bank not EMPTY
protocol_err  output  1  one-cycle pulse on illegal done

Behaviour:
- Clock/reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: all banks EMPTY; wr_ptr = rd_ptr = 0; fetch_grant = consume_grant = 0; rd_lines = 0; stored counts = 0; bank_empty = 2'b11; bank_full = 2'b00; busy = 0; protocol_err = 0. Reset mid-operation discards all state, including outstanding grants.
- Per-bank state (2 bits): EMPTY = 0, FILLING = 1, FULL = 2, DRAINING = 3.
- wr_bank_sel = wr_ptr and rd_bank_sel = rd_ptr, both registered.
- All decisions use registered state only, so a bank freed in cycle N is grantable from cycle N+1.
- Fetch grant: if fetch_req = 1, no write outstanding, and bank[wr_ptr] = EMPTY, then at the next edge bank[wr_ptr] becomes FILLING and fetch_grant = 1 for exactly one cycle. At most one write is outstanding; a held fetch_req produces no further grant until fetch_done.
- fetch_done with bank[wr_ptr] = FILLING:
  - fill_lines != 0: bank becomes FULL, count is stored, wr_ptr toggles.
  - fill_lines = 0 (abort): bank returns to EMPTY, wr_ptr unchanged.
- Consume grant: if consume_req = 1, no read outstanding, and bank[rd_ptr] = FULL, then at the next edge bank becomes DRAINING, consume_grant pulses for one cycle, and rd_lines is loaded with the stored count in the same cycle as the pulse.
- consume_done with bank[rd_ptr] = DRAINING: bank becomes EMPTY and rd_ptr toggles.
- Simultaneous fetch_done and consume_done (necessarily different banks): both applied in the same cycle.
- Same-cycle fetch_done and consume_req on the same bank: grant issued one cycle later.
- Both banks FULL: fetch_req is stalled, no grant.
- Both banks EMPTY: consume_req is stalled, no grant.
- protocol_err pulses, with no state change, on:
  - fetch_done with no write outstanding, or
  - consume_done with no read outstanding.
- flush: all banks EMPTY, ptrs 0, counts 0, no grants issued in the flush cycle, rd_lines retained. Outstanding dones after flush raise protocol_err.

Test Plan:
1. Reset → bank_empty = 11, bank_full = 00, busy = 0. fetch_req = 1 → fetch_grant pulse one cycle later with wr_bank_sel = 0, then no second grant while req is held.
2. fetch_done with fill_lines = 12 → bank_full = 01, wr_bank_sel = 1. consume_req → consume_grant with rd_bank_sel = 0, rd_lines = 12.
3. Fill bank0 (5 lines) and bank1 (7 lines), third fetch_req → no grant until consume_done on bank0; then grant on bank0, wr_bank_sel = 0.
4. fetch_done (bank1, 9 lines) and consume_done (bank0) in the same cycle → bank_empty = 01, bank_full = 10; next consume grant gives rd_lines = 9.
5. fetch_done with fill_lines = 0 → bank back to EMPTY, wr_ptr unchanged. Stray consume_done → protocol_err pulse, status unchanged.
6. flush with bank0 DRAINING and bank1 FILLING → all EMPTY, busy = 0 next cycle. Following fetch_done → protocol_err. Assert rst mid-fill → immediate reset values.
